// File: rtl/eeprom_rw_test_ctrl.sv
// EEPROM write/read-back test sequencer driving an I2C master request port.
// Writes an incrementing pattern, reads it back, and reports pass/fail, retrying on NACK.
module eeprom_rw_test_ctrl #(
    parameter int unsigned NUM_BYTES      = 16,
    parameter logic [7:0]  DEV_ADDR       = 8'hA0,
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter logic        ADDR_2BYTE     = 1'b1,
    parameter int unsigned WR_WAIT_CYCLES = 250000,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  seed,
    output logic        i2c_write_req,
    output logic        i2c_read_req,
    input  logic        i2c_write_req_ack,
    input  logic        i2c_read_req_ack,
    input  logic        i2c_error,
    output logic        i2c_addr_2byte,
    output logic [7:0]  i2c_slave_dev_addr,
    output logic [15:0] i2c_slave_reg_addr,
    output logic [7:0]  i2c_write_data,
    input  logic [7:0]  i2c_read_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        fail_nack,
    output logic [15:0] fail_addr,
    output logic [7:0]  fail_exp,
    output logic [7:0]  fail_got
);

    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int unsigned DLY_W = (WR_WAIT_CYCLES > 1) ? $clog2(WR_WAIT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((WR_WAIT_CYCLES > 0) ? WR_WAIT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_DLY = 3'd2,
        RD_REQ = 3'd3,
        CMP    = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [RTY_W-1:0]  retry;
    logic [DLY_W-1:0]  cnt;
    logic              phase_rd;
    logic [7:0]        seed_q;
    logic [7:0]        rd_q;

    logic [15:0]       cur_addr_c;
    logic [7:0]        exp_data_c;
    logic              can_retry_c;
    logic              last_idx_c;

    assign i2c_addr_2byte     = ADDR_2BYTE;
    assign i2c_slave_dev_addr = DEV_ADDR;

    // Address/pattern for the current index; address wraps at 16 bits.
    assign cur_addr_c  = BASE_ADDR + 16'(idx);
    assign exp_data_c  = seed_q + 8'(idx);
    assign can_retry_c = (32'(retry) < RETRY_MAX);
    assign last_idx_c  = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            idx                <= '0;
            retry              <= '0;
            cnt                <= '0;
            phase_rd           <= 1'b0;
            seed_q             <= 8'h00;
            rd_q               <= 8'h00;
            i2c_write_req      <= 1'b0;
            i2c_read_req       <= 1'b0;
            i2c_slave_reg_addr <= 16'h0000;
            i2c_write_data     <= 8'h00;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            fail               <= 1'b0;
            fail_nack          <= 1'b0;
            fail_addr          <= 16'h0000;
            fail_exp           <= 8'h00;
            fail_got           <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q    <= seed;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_nack <= 1'b0;
                        fail_addr <= 16'h0000;
                        fail_exp  <= 8'h00;
                        fail_got  <= 8'h00;
                        idx       <= '0;
                        retry     <= '0;
                        phase_rd  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WR_REQ;
                    end
                end

                // First cycle in state raises the request; this also keeps a 2-cycle ack-to-req gap.
                WR_REQ: begin
                    if (!i2c_write_req) begin
                        i2c_write_req      <= 1'b1;
                        i2c_slave_reg_addr <= cur_addr_c;
                        i2c_write_data     <= exp_data_c;
                    end else if (i2c_write_req_ack || i2c_read_req_ack) begin
                        i2c_write_req <= 1'b0;
                        if (!i2c_error) begin
                            retry <= '0;
                            cnt   <= '0;
                            state <= WR_DLY;
                            if (last_idx_c) begin
                                idx      <= '0;
                                phase_rd <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else if (can_retry_c) begin
                            retry <= retry + RTY_W'(1);
                            cnt   <= '0;
                            state <= WR_DLY;
                        end else begin
                            fail      <= 1'b1;
                            fail_nack <= 1'b1;
                            fail_addr <= cur_addr_c;
                            state     <= FINISH;
                        end
                    end
                end

                WR_DLY: begin
                    if (cnt == DLY_LAST) begin
                        state <= phase_rd ? RD_REQ : WR_REQ;
                    end else begin
                        cnt <= cnt + DLY_W'(1);
                    end
                end

                // A write ack while reading means the master aborted the read on NACK.
                RD_REQ: begin
                    if (!i2c_read_req) begin
                        i2c_read_req       <= 1'b1;
                        i2c_slave_reg_addr <= cur_addr_c;
                    end else if (i2c_read_req_ack) begin
                        i2c_read_req <= 1'b0;
                        rd_q         <= i2c_read_data;
                        retry        <= '0;
                        state        <= CMP;
                    end else if (i2c_write_req_ack) begin
                        i2c_read_req <= 1'b0;
                        if (can_retry_c) begin
                            retry <= retry + RTY_W'(1);
                            cnt   <= '0;
                            state <= WR_DLY;
                        end else begin
                            fail      <= 1'b1;
                            fail_nack <= 1'b1;
                            fail_addr <= cur_addr_c;
                            state     <= FINISH;
                        end
                    end
                end

                CMP: begin
                    if (rd_q == exp_data_c) begin
                        if (last_idx_c) begin
                            pass  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= RD_REQ;
                        end
                    end else begin
                        fail      <= 1'b1;
                        fail_addr <= cur_addr_c;
                        fail_exp  <= exp_data_c;
                        fail_got  <= rd_q;
                        state     <= FINISH;
                    end
                end

                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
